// File: rtl/bcd_display_loader_if.sv
// Load/display bus between a producer of binary values and the BCD display loader.
// Signal names match the display decoder's BCD/blank inputs.
interface bcd_display_loader_if #(
    parameter int unsigned WIDTH = 27
);
    logic [WIDTH-1:0] value;
    logic             lzb;
    logic             load;
    logic             ready;
    logic             done;
    logic             overflow;
    logic [3:0]       BCD7;
    logic [3:0]       BCD6;
    logic [3:0]       BCD5;
    logic [3:0]       BCD4;
    logic [3:0]       BCD3;
    logic [3:0]       BCD2;
    logic [3:0]       BCD1;
    logic [3:0]       BCD0;
    logic [7:0]       blank;

    modport master (
        output value, lzb, load,
        input  ready, done, overflow,
        input  BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0, blank
    );

    modport slave (
        input  value, lzb, load,
        output ready, done, overflow,
        output BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0, blank
    );
endinterface

// File: rtl/bcd_display_loader.sv
// Iterative double-dabble converter feeding an 8-digit seven-segment display,
// with leading-zero and overflow blanking; display outputs change only on publish.
module bcd_display_loader #(
    parameter int unsigned WIDTH  = 27,
    parameter int unsigned DIGITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    bcd_display_loader_if.slave  bus
);
    localparam int unsigned CNT_W = 6;
    localparam int unsigned ACC_W = 4 * DIGITS;
    localparam logic [WIDTH-1:0] MAX_DISP = WIDTH'(99_999_999);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PUBLISH
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lzb;
    logic             r_ovf_pend;
    logic             r_ready;
    logic             r_done;
    logic             r_overflow;
    logic [ACC_W-1:0] r_bcd;
    logic [7:0]       r_blank;

    logic [ACC_W-1:0] w_acc_adj;
    logic [7:0]       w_lz_mask;
    logic             w_zero_run;

    // Add-3 correction applied to every digit before the shift.
    always_comb begin
        w_acc_adj = r_acc;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Digit i blanks when it and every more significant digit are zero; digit 0 always shows.
    always_comb begin
        w_lz_mask  = 8'h00;
        w_zero_run = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            w_zero_run   = w_zero_run & (r_acc[4*i +: 4] == 4'd0);
            w_lz_mask[i] = w_zero_run;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_lzb      <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_bcd      <= '0;
            r_blank    <= 8'hFF;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.load) begin
                        r_shift    <= bus.value;
                        r_lzb      <= bus.lzb;
                        r_ovf_pend <= (bus.value > MAX_DISP);
                        r_acc      <= '0;
                        r_cnt      <= CNT_W'(WIDTH);
                        r_ready    <= 1'b0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // MSB of the value enters digit 0; carries out of the top digit are dropped.
                    {r_acc, r_shift} <= {w_acc_adj[ACC_W-2:0], r_shift, 1'b0};
                    r_cnt            <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_PUBLISH;
                    end
                end
                S_PUBLISH: begin
                    r_state    <= S_IDLE;
                    r_ready    <= 1'b1;
                    r_done     <= 1'b1;
                    r_overflow <= r_ovf_pend;
                    if (r_ovf_pend) begin
                        r_bcd   <= '0;
                        r_blank <= 8'hFF;
                    end else begin
                        r_bcd   <= r_acc;
                        r_blank <= r_lzb ? w_lz_mask : 8'h00;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready    = r_ready;
    assign bus.done     = r_done;
    assign bus.overflow = r_overflow;
    assign bus.BCD0     = r_bcd[3:0];
    assign bus.BCD1     = r_bcd[7:4];
    assign bus.BCD2     = r_bcd[11:8];
    assign bus.BCD3     = r_bcd[15:12];
    assign bus.BCD4     = r_bcd[19:16];
    assign bus.BCD5     = r_bcd[23:20];
    assign bus.BCD6     = r_bcd[27:24];
    assign bus.BCD7     = r_bcd[31:28];
    assign bus.blank    = r_blank;

endmodule
